// File: rtl/csa_pkg.sv
// csa_pkg: shared FSM state type and default operand/chunk widths for csa_resolver
package csa_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 16;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: stateless W-bit adder; a, b, cin -> sum, cout
module chunk_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save sum/carry pair to binary CHUNK bits per cycle; in_valid/in_ready accept, out_valid/out_ready deliver result/cout
module csa_resolver
  import csa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW = NCH > 1 ? $clog2(NCH) : 1;
  if (WIDTH % CHUNK != 0) begin : g_width_chk
    $error("csa_resolver: WIDTH must be a multiple of CHUNK");
  end
  state_t state, nxt;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CHUNK-1:0] s;
  logic c, co, last;
  chunk_adder #(.W(CHUNK)) u_add (
    .a(a_r[k*CHUNK +: CHUNK]),
    .b(b_r[k*CHUNK +: CHUNK]),
    .cin(c),
    .sum(s),
    .cout(co)
  );
  assign last = k == KW'(NCH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    nxt = state;
    nxt = (state == IDLE && in_valid) ? ADD :
          (state == ADD && last) ? DONE :
          (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      c <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      result <= '0;
      cout <= 1'b0;
    end else begin
      state <= nxt;
      if (in_ready && in_valid) begin
        a_r <= sum_in;
        b_r <= carry_in;
        k <= '0;
        c <= 1'b0;
      end else if (state == ADD) begin
        result[k*CHUNK +: CHUNK] <= s;
        c <= co;
        k <= k + 1'b1;
        if (last) cout <= co;
      end
    end
  end
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed and random self-checking bench for csa_resolver at default widths
module tb_csa_resolver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [63:0] sum_in = '0;
  logic [63:0] carry_in = '0;
  logic in_ready, out_valid, cout;
  logic [63:0] result;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  csa_resolver dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sum_in(sum_in),
    .carry_in(carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .cout(cout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      tick();
      n++;
    end
  endtask
  task automatic txn(input logic [63:0] s, input logic [63:0] c, input logic [63:0] er, input logic eco);
    int n;
    sum_in = s;
    carry_in = c;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("accept", 64'(in_ready), 64'd0);
    wait_done(n);
    chk("latency", 64'(n), 64'd4);
    chk("result", result, er);
    chk("cout", 64'(cout), 64'(eco));
    chk("done_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handshake_valid", 64'(out_valid), 64'd0);
    chk("handshake_idle", 64'(in_ready), 64'd1);
  endtask
  initial begin
    int n, t0;
    logic [63:0] a, b, c, s, cr;
    logic [64:0] full;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    // first edge after release must accept
    txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1);
    txn(64'h5, 64'h3, 64'h8, 1'b0);
    // backpressure in DONE with inputs wiggling
    sum_in = 64'h8000_0000_0000_0000;
    carry_in = 64'h8000_0000_0000_0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    chk("bp_latency", 64'(n), 64'd4);
    for (int i = 0; i < 10; i++) begin
      sum_in = {$urandom, $urandom};
      carry_in = {$urandom, $urandom};
      in_valid = 1'(i);
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", result, 64'h1);
      chk("bp_cout", 64'(cout), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", 64'(out_valid), 64'd0);
    chk("bp_idle", 64'(in_ready), 64'd1);
    tick();
    chk("bp_single", 64'(out_valid), 64'd0);
    // reset asserted around the 2nd ADD edge
    sum_in = 64'h1234;
    carry_in = 64'h4321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_result", result, 64'd0);
    chk("mrst_cout", 64'(cout), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mrst_quiet", 64'(out_valid), 64'd0);
      chk("mrst_idle", 64'(in_ready), 64'd1);
    end
    // back-to-back with in_valid and out_ready held high
    sum_in = 64'h0000_0000_FFFF_0000;
    carry_in = 64'h0000_0000_0001_0000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("b2b_accept1", 64'(in_ready), 64'd0);
    t0 = cyc;
    sum_in = 64'hFFFF_FFFF_FFFF_FFFF;
    carry_in = 64'hFFFF_FFFF_FFFF_FFFE;
    wait_done(n);
    chk("b2b_latency1", 64'(n), 64'd4);
    chk("b2b_result1", result, 64'h0000_0001_0000_0000);
    chk("b2b_cout1", 64'(cout), 64'd0);
    tick();
    chk("b2b_hs_valid", 64'(out_valid), 64'd0);
    chk("b2b_hs_idle", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_accept2", 64'(in_ready), 64'd0);
    chk("b2b_spacing", 64'(cyc - t0), 64'd6);
    in_valid = 1'b0;
    wait_done(n);
    chk("b2b_latency2", 64'(n), 64'd4);
    chk("b2b_result2", result, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("b2b_cout2", 64'(cout), 64'd1);
    tick();
    out_ready = 1'b0;
    chk("b2b_end", 64'(in_ready), 64'd1);
    // random triples reduced 3:2 then resolved
    for (int i = 0; i < 10000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      s = a ^ b ^ c;
      cr = ((a & b) | (a & c) | (b & c)) << 1;
      full = {1'b0, s} + {1'b0, cr};
      chk("rand_model", a + b + c, full[63:0]);
      txn(s, cr, a + b + c, full[64]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16: bits resolved per cycle; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand pair presented.
REQ-006 SHALL have port in_ready, output, 1: block idle and able to accept.
REQ-007 SHALL have port sum_in, input, WIDTH: redundant-form sum vector.
REQ-008 SHALL have port carry_in, input, WIDTH: redundant-form carry vector, already weight-aligned (bit 0 normally 0).
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port result, output, WIDTH: (sum_in + carry_in) mod 2^WIDTH.
REQ-012 SHALL have port cout, output, 1: bit WIDTH of sum_in + carry_in.

Function
REQ-013 SHALL use a three-state FSM: IDLE, ADD, DONE.
REQ-014 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-015 SHALL accept on a rising edge with in_valid & in_ready: latch both vectors, clear chunk index k and internal carry, go to ADD.
REQ-016 SHALL in ADD, each edge, add chunk k of both latched vectors plus internal carry, write CHUNK bits to result[k], update internal carry, increment k.
REQ-017 SHALL go from ADD to DONE on the edge processing k = NCH-1; cout takes the final carry on that edge.
REQ-018 SHALL raise out_valid exactly NCH edges after the accepting edge (4 at defaults).
REQ-019 SHALL hold result, cout, out_valid stable in DONE until out_valid & out_ready on an edge, then go to IDLE.
REQ-020 SHALL ignore in_valid, sum_in, carry_in outside IDLE; latched operands are unaffected by input changes after acceptance.
REQ-021 SHALL not accept in the same cycle it completes a DONE handshake (in_ready low in DONE); per-transaction minimum period is NCH+2 cycles.
REQ-022 SHALL propagate carry across all chunk boundaries (full ripple from bit 0 to cout).
REQ-023 SHALL keep result and cout holding the previous transaction's values in IDLE and ADD until overwritten; they are meaningful only while out_valid is high.
REQ-024 SHALL flag an elaboration error when WIDTH is not a multiple of CHUNK.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, k = 0, internal carry 0, result 0, cout 0, out_valid 0, in_ready 1.
REQ-026 SHALL, when reset is asserted mid-ADD or in DONE, abandon the transaction with no output produced after release.
REQ-027 SHALL be able to accept on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place the state enum typedef and the WIDTH/CHUNK defaults in shared package csa_pkg.
REQ-029 SHALL instantiate one combinational sub-module chunk_adder (CHUNK-bit a, b, cin -> sum, cout) for the per-cycle add.
REQ-030 SHALL keep all registers in csa_resolver; chunk_adder stays stateless.

Verification
REQ-031 SHALL cover full ripple: sum_in=0xFFFF_FFFF_FFFF_FFFF, carry_in=0x1 -> result 0x0, cout 1, out_valid 4 edges after accept.
REQ-032 SHALL cover a simple case: sum_in=0x5, carry_in=0x3 -> result 0x8, cout 0; in_ready low from accept to the DONE handshake.
REQ-033 SHALL cover backpressure: out_ready low 10 cycles in DONE -> out_valid, result, cout constant; sum_in changes ignored; a single handshake when out_ready rises.
REQ-034 SHALL cover reset mid-operation: rst_n pulsed low on the 2nd ADD edge -> out_valid 0, result 0, in_ready 1 immediately; no out_valid until a new accept.
REQ-035 SHALL cover back-to-back traffic: in_valid and out_ready held high for two transactions -> second accepted on the edge after IDLE is re-entered; spacing 6 cycles at defaults.
REQ-036 SHALL cover 10k random a, b, c: reduce each triple with a bitwise 3:2 carry-save reduction, resolve the resulting sum/carry pair through csa_resolver -> result == (a+b+c) mod 2^64.
